mem_arbiter: RTL and testbench

Single-port memory arbiter for the five-stage RV32I pipeline. It shares one unified, pipelined, fixed-latency memory port between the fetch stage (instruction reads) and the memory stage (loads and stores). Data accesses have priority, and a starvation counter prevents indefinite fetch lockout. The arbiter tags every in-flight read so returning data is steered to the correct requester, and it squashes in-flight fetches on a pipeline redirect.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/arb_tag_pipe.sv | 45 ++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: requester ownership,
// access-size encodings and the arbitration priority states.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    DPRI = 1'b0,
    FPRI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_size;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              flush;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, flush, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, flush, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );

endinterface

// File: rtl/arb_tag_pipe.sv
// DEPTH-stage shift register of {valid, owner} tracking in-flight reads.
// kill_if_i drops every fetch-owned entry, including the one entering this cycle.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid_i,
  input  owner_e in_owner_i,
  input  logic   kill_if_i,
  output logic   out_valid_o,
  output owner_e out_owner_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  owner_e           own_q [DEPTH];
  owner_e           own_d [DEPTH];

  always_comb begin
    valid_d    = '0;
    own_d      = own_q;
    valid_d[0] = in_valid_i & ~(kill_if_i & (in_owner_i == OWN_IF));
    own_d[0]   = in_owner_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1] & ~(kill_if_i & (own_q[i-1] == OWN_IF));
      own_d[i]   = own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) own_q[i] <= OWN_IF;
    end else begin
      valid_q <= valid_d;
      own_q   <= own_d;
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_owner_o = own_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between fetch and data accesses.
// Data has priority; a starvation counter hands fetch one priority cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d, starve_nxt;

  logic              if_gnt, d_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              tag_v;
  owner_e            tag_own, tag_own_in;

  // Grants are zero-cycle; flush blocks fetch but never data.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if (state_q == FPRI) begin
        if_gnt = bus.if_req & ~bus.flush;
        d_gnt  = bus.d_req & ~if_gnt;
      end else begin
        d_gnt  = bus.d_req;
        if_gnt = bus.if_req & ~bus.d_req & ~bus.flush;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    starve_nxt = starve_q + 1'b1;
    if (if_gnt || !bus.if_req || bus.flush) starve_d = '0;
    else if (d_gnt)                         starve_d = starve_nxt;
    case (state_q)
      DPRI: if (d_gnt && bus.if_req && !bus.flush && starve_nxt == STARVE_LIM) state_d = FPRI;
      FPRI: if (if_gnt || !bus.if_req || bus.flush) state_d = DPRI;
      default: state_d = DPRI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= DPRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    if (d_gnt) begin
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
      mem_size  = bus.d_size;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
      mem_size  = SZ_WORD;
    end
  end

  assign tag_own_in = if_gnt ? OWN_IF : OWN_D;

  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tags (
    .clk         (clock),
    .rst_n       (reset),
    .in_valid_i  (if_gnt | (d_gnt & ~bus.d_we)),
    .in_owner_i  (tag_own_in),
    .kill_if_i   (bus.flush),
    .out_valid_o (tag_v),
    .out_owner_o (tag_own)
  );

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_req   = if_gnt | d_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_size  = mem_size;
  assign bus.if_rvalid = tag_v & (tag_own == OWN_IF);
  assign bus.d_rvalid  = tag_v & (tag_own == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT 1, 2 and 3; expected read returns
// are queued at stimulus time and consumed by a negedge monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns a cycle-stamped word, so rdata identifies its return cycle.
  logic [15:0] cyc16;
  assign cyc16 = cyc[15:0];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  assign b1.mem_rdata = {16'hDA7A, cyc16};
  assign b2.mem_rdata = {16'hDA7A, cyc16};
  assign b3.mem_rdata = {16'hDA7A, cyc16};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clock(clk), .reset(rst_n), .bus(b1));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut2 (
    .clock(clk), .reset(rst_n), .bus(b2));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clock(clk), .reset(rst_n), .bus(b3));

  typedef struct {
    int     cyc;
    owner_e own;
  } exp_t;

  exp_t sb [3][$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input int k, input int lat, input owner_e own);
    exp_t e;
    e.cyc = cyc + lat;
    e.own = own;
    sb[k].push_back(e);
  endtask

  task automatic pop_cmp(input int k, input owner_e own, input logic [31:0] rdata);
    exp_t e;
    if (sb[k].size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_rvalid dut%0d: got rvalid owner %0d, want none (cycle %0d)",
               k + 1, own, cyc);
    end else begin
      e = sb[k].pop_front();
      check($sformatf("rvalid_cycle_dut%0d", k + 1), cyc, e.cyc);
      check($sformatf("rvalid_owner_dut%0d", k + 1), {31'd0, own}, {31'd0, e.own});
      check($sformatf("rdata_dut%0d", k + 1), rdata, {16'hDA7A, e.cyc[15:0]});
    end
  endtask

  task automatic mon(input int k, input logic irv, input logic drv,
                     input logic [31:0] ird, input logic [31:0] drd);
    while (sb[k].size() > 0 && sb[k][0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_rvalid dut%0d: got none, want owner %0d at cycle %0d",
               k + 1, sb[k][0].own, sb[k][0].cyc);
      void'(sb[k].pop_front());
    end
    if (irv) pop_cmp(k, OWN_IF, ird);
    if (drv) pop_cmp(k, OWN_D, drd);
  endtask

  always @(negedge clk) begin
    mon(0, b1.if_rvalid, b1.d_rvalid, b1.if_rdata, b1.d_rdata);
    mon(1, b2.if_rvalid, b2.d_rvalid, b2.if_rdata, b2.d_rdata);
    mon(2, b3.if_rvalid, b3.d_rvalid, b3.if_rdata, b3.d_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0;
    b1.d_wdata = '0; b1.d_size = 2'd0; b1.flush = 0;
    b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0;
    b2.d_wdata = '0; b2.d_size = 2'd0; b2.flush = 0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0;
    b3.d_wdata = '0; b3.d_size = 2'd0; b3.flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit     fetch_turn;
    owner_e own;
    idle_all();

    // Reset asserted with requests pending: nothing may be granted.
    #1 rst_n = 1'b0;
    b1.if_req = 1; b1.if_addr = 32'h0100_0000; b1.d_req = 1; b1.d_addr = 32'h2000;
    b3.if_req = 1; b3.d_req = 1;
    #2;
    check("rst_if_gnt",    b1.if_gnt, 0);
    check("rst_d_gnt",     b1.d_gnt, 0);
    check("rst_mem_req",   b1.mem_req, 0);
    check("rst_mem_addr",  b1.mem_addr, 32'h0);
    check("rst_if_rvalid", b1.if_rvalid, 0);
    check("rst_d_rvalid",  b1.d_rvalid, 0);
    check("rst_mem_req3",  b3.mem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    idle_all();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_mem_req",   b1.mem_req, 0);
    check("idle_mem_we",    b1.mem_we, 0);
    check("idle_mem_addr",  b1.mem_addr, 32'h0);
    check("idle_mem_wdata", b1.mem_wdata, 32'h0);
    check("idle_mem_size",  b1.mem_size, 0);

    // Fetch only, latency 1.
    step();
    b1.if_req = 1; b1.if_addr = 32'h0100_0000;
    expect_rd(0, 1, OWN_IF);
    @(negedge clk);
    check("f_if_gnt",   b1.if_gnt, 1);
    check("f_d_gnt",    b1.d_gnt, 0);
    check("f_mem_req",  b1.mem_req, 1);
    check("f_mem_addr", b1.mem_addr, 32'h0100_0000);
    check("f_mem_size", b1.mem_size, 2);
    check("f_mem_we",   b1.mem_we, 0);
    step();
    b1.if_req = 0;
    @(negedge clk);
    check("f_after_mem_req", b1.mem_req, 0);
    repeat (2) step();

    // Contention: data wins, held fetch follows.
    step();
    b1.if_req = 1; b1.if_addr = 32'h0100_0004;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h2000; b1.d_size = 2;
    expect_rd(0, 1, OWN_D);
    @(negedge clk);
    check("c_d_gnt",    b1.d_gnt, 1);
    check("c_if_gnt",   b1.if_gnt, 0);
    check("c_mem_addr", b1.mem_addr, 32'h2000);
    step();
    b1.d_req = 0;
    expect_rd(0, 1, OWN_IF);
    @(negedge clk);
    check("c_if_gnt2",   b1.if_gnt, 1);
    check("c_mem_addr2", b1.mem_addr, 32'h0100_0004);
    step();
    b1.if_req = 0;
    repeat (2) step();

    // Starvation: four data grants, one forced fetch, then data again.
    for (int i = 0; i < 6; i++) begin
      step();
      b1.if_req = 1; b1.if_addr = 32'h0100_0008;
      b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h3000 + 32'(4 * i);
      fetch_turn = (i == 4);
      own = fetch_turn ? OWN_IF : OWN_D;
      expect_rd(0, 1, own);
      @(negedge clk);
      check($sformatf("s_d_gnt_%0d", i),  b1.d_gnt, !fetch_turn);
      check($sformatf("s_if_gnt_%0d", i), b1.if_gnt, fetch_turn);
      check($sformatf("s_state_%0d", i),  {31'd0, dut1.state_q}, fetch_turn ? 1 : 0);
    end
    step();
    idle_all();
    repeat (2) step();

    // Stores: payload on the port, no read return.
    step();
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h2004; b1.d_wdata = 32'hDEAD_BEEF; b1.d_size = 2;
    @(negedge clk);
    check("st_d_gnt",     b1.d_gnt, 1);
    check("st_mem_req",   b1.mem_req, 1);
    check("st_mem_we",    b1.mem_we, 1);
    check("st_mem_addr",  b1.mem_addr, 32'h2004);
    check("st_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_size",  b1.mem_size, 2);
    step();
    b1.d_addr = 32'h2007; b1.d_wdata = 32'h0000_00AB; b1.d_size = 0;
    @(negedge clk);
    check("stb_mem_size",  b1.mem_size, 0);
    check("stb_mem_wdata", b1.mem_wdata, 32'h0000_00AB);
    step();
    idle_all();
    repeat (3) step();

    // Flush at latency 2: in-flight fetch killed, load unaffected.
    step();
    b2.if_req = 1; b2.if_addr = 32'h0100_0100;
    @(negedge clk);
    check("fl_if_gnt0", b2.if_gnt, 1);
    step();
    b2.if_addr = 32'h0100_0104; b2.flush = 1;
    b2.d_req = 1; b2.d_addr = 32'h2010; b2.d_size = 2;
    expect_rd(1, 2, OWN_D);
    @(negedge clk);
    check("fl_if_gnt1",   b2.if_gnt, 0);
    check("fl_d_gnt1",    b2.d_gnt, 1);
    check("fl_mem_addr1", b2.mem_addr, 32'h2010);
    step();
    b2.flush = 0; b2.d_req = 0;
    expect_rd(1, 2, OWN_IF);
    @(negedge clk);
    check("fl_if_gnt2", b2.if_gnt, 1);
    step();
    b2.if_req = 0;
    step();
    // Fetch whose data returns in the flush cycle survives.
    b2.if_req = 1; b2.if_addr = 32'h0100_0200;
    expect_rd(1, 2, OWN_IF);
    @(negedge clk);
    check("fl_if_gnt3", b2.if_gnt, 1);
    step();
    b2.if_req = 0;
    step();
    b2.flush = 1;
    @(negedge clk);
    check("fl_keep_if_rvalid", b2.if_rvalid, 1);
    step();
    b2.flush = 0;
    repeat (3) step();

    // Reset mid-flight at latency 3.
    step();
    b3.d_req = 1; b3.d_addr = 32'h2020; b3.if_req = 1; b3.if_addr = 32'h0100_0300;
    @(negedge clk);
    check("rm_d_gnt0", b3.d_gnt, 1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_if_gnt",  b3.if_gnt, 0);
    check("rm_d_gnt",   b3.d_gnt, 0);
    check("rm_mem_req", b3.mem_req, 0);
    check("rm_state",   {31'd0, dut3.state_q}, 0);
    check("rm_starve",  32'(dut3.starve_q), 0);
    step();
    idle_all();
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_state_rel",  {31'd0, dut3.state_q}, 0);
    check("rm_starve_rel", 32'(dut3.starve_q), 0);
    repeat (2) step();
    b3.if_req = 1; b3.if_addr = 32'h0100_0000;
    expect_rd(2, 3, OWN_IF);
    @(negedge clk);
    check("rm_f_if_gnt",   b3.if_gnt, 1);
    check("rm_f_mem_addr", b3.mem_addr, 32'h0100_0000);
    step();
    b3.if_req = 0;
    repeat (5) step();

    check("sb_empty_dut1", sb[0].size(), 0);
    check("sb_empty_dut2", sb[1].size(), 0);
    check("sb_empty_dut3", sb[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
